i2c_slave_regfile: RTL and testbench

- I2C target (responder) that answers a 7-bit-address, 1-byte-register-address, 1-byte-data protocol.
- Backs the protocol with an internal 256x8 register file.
- Used as the bus-side model of the HDMI transmitter in simulation, and as an on-FPGA configuration target for the board controller.
- Supports sub-address writes with auto-increment, random reads via repeated START, and sequential reads.

---
 rtl/i2c_slave_regfile.sv | 185 ++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile
//   I2C target answering a 7-bit device address / 1-byte register address /
//   1-byte data protocol, backed by a 256x8 register file. Supports
//   auto-incrementing sub-address writes, random reads through a repeated
//   START and sequential reads.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   scl_in     raw SCL from the pad (asynchronous)
//   sda_in     raw SDA from the pad (asynchronous)
//   sda_oen    0 pulls SDA low, 1 releases it (open drain)
//   wr_strobe  one-cycle pulse per data byte written from the bus
//   wr_addr    register address of the last bus write
//   wr_data    data of the last bus write
//   host_addr  host-side read address
//   host_data  regfile[host_addr], one cycle latency
//   busy       high from START until STOP
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oen,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_REG  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_IGN  = 3'd5;

  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] ptr;
  logic       ack_ph;    // between the 8th rising edge and the end of the 9th clock
  logic       ack_seen;  // 9th rising edge has happened
  logic       ack_go;    // target drives ACK during the 9th clock
  logic [7:0] mem [256];

  logic       scl_rise, scl_fall, start_cond, stop_cond, active, mem_we;
  logic [7:0] rx_byte;

  // Stage p0/p1: two-flop synchronizer; stage p2: history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_cond = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
  assign stop_cond  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
  assign active     = (state == S_ADDR) || (state == S_REG) ||
                      (state == S_WR)   || (state == S_RD);
  assign rx_byte    = {shift[6:0], sda_p1};
  assign mem_we     = !start_cond && !stop_cond && active && scl_rise &&
                      !ack_ph && (bit_cnt == 3'd7) && (state == S_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      ptr       <= 8'h00;
      ack_ph    <= 1'b0;
      ack_seen  <= 1'b0;
      ack_go    <= 1'b0;
      sda_oen   <= 1'b1;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_cond) begin
        state    <= S_ADDR;
        bit_cnt  <= 3'd0;
        ack_ph   <= 1'b0;
        ack_seen <= 1'b0;
        ack_go   <= 1'b0;
        sda_oen  <= 1'b1;
        busy     <= 1'b1;
      end else if (stop_cond) begin
        state    <= S_IDLE;
        bit_cnt  <= 3'd0;
        ack_ph   <= 1'b0;
        ack_seen <= 1'b0;
        ack_go   <= 1'b0;
        sda_oen  <= 1'b1;
        busy     <= 1'b0;
      end else if (active && scl_rise) begin
        if (!ack_ph) begin
          // While transmitting, the shift register only moves the next bit to the MSB
          shift   <= (state == S_RD) ? {shift[6:0], 1'b1} : rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ack_ph <= 1'b1;
            case (state)
              S_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  ack_go <= 1'b1;
                  state  <= rx_byte[0] ? S_RD : S_REG;
                end else begin
                  ack_ph <= 1'b0;
                  state  <= S_IGN;
                end
              end
              S_REG: begin
                ptr    <= rx_byte;
                ack_go <= 1'b1;
                state  <= S_WR;
              end
              S_WR: begin
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 8'd1;
                ack_go    <= 1'b1;
              end
              default: begin
                ptr    <= ptr + 8'd1;
                ack_go <= 1'b0;
              end
            endcase
          end
        end else begin
          ack_seen <= 1'b1;
          // Master NACK after a read byte ends the read
          if ((state == S_RD) && !ack_go && sda_p1) begin
            state    <= S_IGN;
            ack_ph   <= 1'b0;
            ack_seen <= 1'b0;
          end
        end
      end else if (active && scl_fall) begin
        if (ack_ph && !ack_seen) begin
          sda_oen <= ~ack_go;
        end else if (ack_ph) begin
          ack_ph   <= 1'b0;
          ack_seen <= 1'b0;
          ack_go   <= 1'b0;
          if (state == S_RD) begin
            shift   <= mem[ptr];
            sda_oen <= mem[ptr][7];
          end else begin
            sda_oen <= 1'b1;
          end
        end else if (state == S_RD) begin
          sda_oen <= shift[7];
        end
      end
    end
  end

  // host_data reads the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= RST_VAL;
      host_data <= RST_VAL;
    end else begin
      if (mem_we) mem[ptr] <= rx_byte;
      host_data <= mem[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
module tb_i2c_slave_regfile;
  localparam logic [6:0] DEV = 7'h39;
  localparam int Q = 5;
  localparam int P_IDLE = 0, P_ADDR = 1, P_REG = 2, P_DATA = 3, P_RD = 4, P_IGN = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oen, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data, host_data;
  logic [7:0] host_addr = 8'h00;
  wire        sda_bus = sda_m & sda_oen;

  i2c_slave_regfile #(.DEV_ADDR(7'h39), .RST_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oen(sda_oen), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .host_addr(host_addr), .host_data(host_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model
  logic [7:0]  model_mem [256];
  logic [7:0]  mptr = 8'h00;
  int          mphase = P_IDLE;
  logic        model_busy = 1'b0;
  logic [15:0] exp_wr_q [$];
  int          strobe_cnt = 0;
  logic [7:0]  last_wa = 8'h00, last_wd = 8'h00;
  logic        hchk = 1'b0, rel_only = 1'b0, quiet = 1'b0;
  logic [7:0]  host_q = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) host_q <= host_addr;

  always @(negedge clk) begin
    if (!reset) begin
      if (hchk) chk("host_data", host_data, model_mem[host_q]);
      if (wr_strobe) begin
        strobe_cnt++;
        last_wa = wr_addr;
        last_wd = wr_data;
        if (exp_wr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_wr_strobe: wr_addr=%h wr_data=%h, no write expected", wr_addr, wr_data);
        end else begin
          logic [15:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", wr_addr, e[15:8]);
          chk("wr_data", wr_data, e[7:0]);
          model_mem[e[15:8]] = e[7:0];
        end
      end
      if (rel_only) chk("sda_released", sda_oen, 1);
      if (quiet) chk("busy_idle", busy, model_busy);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    r = sda_bus;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic m_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
    mphase = P_ADDR;
    model_busy = 1'b1;
  endtask

  task automatic m_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
    mphase = P_IDLE;
    model_busy = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b, output logic acked);
    logic exp_ack;
    logic r;
    exp_ack = 1'b0;
    case (mphase)
      P_ADDR: begin
        if (b[7:1] == DEV) begin
          exp_ack = 1'b1;
          mphase = b[0] ? P_RD : P_REG;
        end else begin
          mphase = P_IGN;
        end
      end
      P_REG: begin
        exp_ack = 1'b1;
        mptr = b;
        mphase = P_DATA;
      end
      P_DATA: begin
        exp_ack = 1'b1;
        exp_wr_q.push_back({mptr, b});
        mptr = mptr + 8'd1;
      end
      default: exp_ack = 1'b0;
    endcase
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    acked = ~r;
    chk("ack", acked, exp_ack);
  endtask

  task automatic rx_byte(input logic mack, output logic [7:0] d);
    logic [7:0] e;
    logic r;
    e = model_mem[mptr];
    mptr = mptr + 8'd1;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, r);
      d = {d[6:0], r};
    end
    clock_bit(~mack, r);
    chk("read_byte", d, e);
    if (!mack) mphase = P_IGN;
  endtask

  task automatic host_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    @(posedge clk);
    #1 host_addr = a;
    @(posedge clk);
    #1 chk(name, host_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a1, a2, a3;
    logic r;
    logic [7:0] d;
    int s0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    // Reset state
    wait_clk(3);
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_host_data", host_data, 8'h00);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    wait_clk(2);
    hchk = 1'b1;
    quiet = 1'b1;

    // Single write
    quiet = 1'b0;
    s0 = strobe_cnt;
    host_addr = 8'h41;
    m_start();
    tx_byte(8'h72, a1);
    chk("t1_busy_mid", busy, 1);
    tx_byte(8'h41, a2);
    tx_byte(8'h40, a3);
    m_stop();
    quiet = 1'b1;
    chk("t1_ack_count", int'(a1) + int'(a2) + int'(a3), 3);
    chk("t1_strobe_count", strobe_cnt - s0, 1);
    chk("t1_wr_addr", last_wa, 8'h41);
    chk("t1_wr_data", last_wd, 8'h40);
    host_rd("t1_host_41", 8'h41, 8'h40);
    chk("t1_busy_after_stop", busy, 0);

    // Wrong address
    quiet = 1'b0;
    rel_only = 1'b1;
    s0 = strobe_cnt;
    m_start();
    tx_byte(8'h70, a1);
    chk("t2_no_ack", a1, 0);
    tx_byte(8'h11, a1);
    tx_byte(8'h22, a1);
    tx_byte(8'h33, a1);
    m_stop();
    rel_only = 1'b0;
    quiet = 1'b1;
    chk("t2_strobe_count", strobe_cnt - s0, 0);
    host_rd("t2_host_41", 8'h41, 8'h40);
    host_rd("t2_host_11", 8'h11, 8'h00);

    // Random read (host_addr parked on A2 across the write exercises the collision)
    quiet = 1'b0;
    host_addr = 8'hA2;
    m_start();
    tx_byte(8'h72, a1);
    tx_byte(8'hA2, a1);
    tx_byte(8'hA4, a1);
    m_stop();
    m_start();
    tx_byte(8'h72, a1);
    tx_byte(8'hA2, a1);
    m_start();
    tx_byte(8'h73, a1);
    chk("t3_read_addr_ack", a1, 1);
    rx_byte(1'b0, d);
    rel_only = 1'b1;
    chk("t3_read_value", d, 8'hA4);
    m_stop();
    rel_only = 1'b0;
    quiet = 1'b1;
    host_rd("t3_host_A2", 8'hA2, 8'hA4);

    // Burst write with pointer wrap
    quiet = 1'b0;
    s0 = strobe_cnt;
    m_start();
    tx_byte(8'h72, a1);
    tx_byte(8'hFE, a1);
    tx_byte(8'h11, a1);
    tx_byte(8'h22, a1);
    tx_byte(8'h33, a1);
    m_stop();
    quiet = 1'b1;
    chk("t4_strobe_count", strobe_cnt - s0, 3);
    chk("t4_last_wr_addr", last_wa, 8'h00);
    host_rd("t4_host_FE", 8'hFE, 8'h11);
    host_rd("t4_host_FF", 8'hFF, 8'h22);
    host_rd("t4_host_00", 8'h00, 8'h33);

    // STOP mid-byte
    quiet = 1'b0;
    s0 = strobe_cnt;
    m_start();
    tx_byte(8'h72, a1);
    tx_byte(8'h98, a1);
    clock_bit(1'b1, r);
    clock_bit(1'b0, r);
    clock_bit(1'b1, r);
    clock_bit(1'b0, r);
    m_stop();
    quiet = 1'b1;
    chk("t5_strobe_count", strobe_cnt - s0, 0);
    chk("t5_busy_idle", busy, 0);
    host_rd("t5_host_98", 8'h98, 8'h00);
    quiet = 1'b0;
    m_start();
    tx_byte(8'h72, a1);
    chk("t5_next_addr_ack", a1, 1);
    tx_byte(8'h10, a1);
    tx_byte(8'h5C, a2);
    chk("t5_next_data_ack", a2, 1);
    m_stop();
    quiet = 1'b1;
    host_rd("t5_host_10", 8'h10, 8'h5C);

    // Reset while the target drives a 0 bit (A2 holds 1010_0100)
    quiet = 1'b0;
    m_start();
    tx_byte(8'h72, a1);
    tx_byte(8'hA2, a1);
    m_start();
    tx_byte(8'h73, a1);
    clock_bit(1'b1, r);
    chk("t6_first_bit", r, 1);
    chk("t6_target_drives_0", sda_oen, 0);
    hchk = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_sda_released", sda_oen, 1);
    chk("t6_busy", busy, 0);
    chk("t6_wr_addr", wr_addr, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    exp_wr_q.delete();
    mptr = 8'h00;
    mphase = P_IDLE;
    model_busy = 1'b0;
    wait_clk(2);
    hchk = 1'b1;
    m_stop();
    quiet = 1'b1;
    host_rd("t6_host_A2", 8'hA2, 8'h00);
    host_rd("t6_host_FE", 8'hFE, 8'h00);
    host_rd("t6_host_41", 8'h41, 8'h00);
    quiet = 1'b0;
    m_start();
    tx_byte(8'h73, a1);
    rx_byte(1'b0, d);
    chk("t6_read_ptr0", d, 8'h00);
    m_stop();
    quiet = 1'b1;
    wait_clk(4);

    chk("wr_queue_empty", exp_wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
